shift_sub_div_sign: RTL and testbench

- Signed sequential shift-subtract (restoring) divider, one quotient bit per clock; the inverse companion of the signed add-shift multiplier.
- Uses the same start / done / aval / dout-valid handshake style as the multiplier, so both blocks share one controller harness.
- Produces quotient and remainder with truncation toward zero, matching Verilog signed `/` and `%`.

---
 rtl/shift_sub_div_sign_pkg.sv | 17 +
 rtl/shift_sub_div_sign_if.sv | 25 ++
 rtl/shift_sub_div_sign_div_abs.sv | 11 +
 rtl/shift_sub_div_sign.sv | 104 ++++++++++
 tb/tb_shift_sub_div_sign.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/shift_sub_div_sign_pkg.sv
// Shared definitions for the sequential divide/multiply controllers:
// FSM encoding and the operand/counter width check.
package shift_sub_div_sign_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Divisor may not be wider than the dividend, and the counter must reach N.
  function automatic bit div_widths_ok(int n, int m, int logn);
    return (m <= n) && ((1 << logn) > n);
  endfunction

endpackage

// File: rtl/shift_sub_div_sign_if.sv
// Start/done/available handshake plus operand and result buses of the divider.
interface shift_sub_div_sign_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic                start;
  logic signed [N-1:0] A;
  logic signed [M-1:0] B;
  logic signed [N-1:0] Q;
  logic signed [M-1:0] R;
  logic                DIV_done;
  logic                DIV_aval;
  logic                DOUT_aval;
  logic                DIV_err;

  modport master (
    output start, A, B,
    input  Q, R, DIV_done, DIV_aval, DOUT_aval, DIV_err
  );

  modport slave (
    input  start, A, B,
    output Q, R, DIV_done, DIV_aval, DOUT_aval, DIV_err
  );
endinterface

// File: rtl/shift_sub_div_sign_div_abs.sv
// Combinational conditional two's-complement negate; yields the magnitude of a
// signed value when neg is its sign bit, or applies a sign to a magnitude.
module div_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/shift_sub_div_sign.sv
// Signed restoring divider, one quotient bit per clock on operand magnitudes,
// sign applied in a final step; Q/R truncate toward zero like Verilog / and %.
module shift_sub_div_sign
  import shift_sub_div_sign_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int logN = 4
) (
  input logic            clk,
  input logic            rst,
  shift_sub_div_sign_if.slave io
);

  if (!div_widths_ok(N, M, logN)) begin : g_bad_width
    $error("shift_sub_div_sign: need M <= N and 2**logN > N");
  end

  div_state_e      state_q, state_d;
  logic [logN-1:0] cnt_q;
  logic            sa_q, sb_q;
  logic [M-1:0]    absb_q;
  logic [M-1:0]    p_q;
  logic [N-1:0]    d_q;

  logic [N-1:0]    abs_a, q_sgn;
  logic [M-1:0]    abs_b, r_sgn;
  logic [M:0]      p_sh;
  logic            take, accept, last_step;

  div_abs #(.W(N)) u_abs_a (.a(io.A),   .neg(io.A[N-1]),   .y(abs_a));
  div_abs #(.W(M)) u_abs_b (.a(io.B),   .neg(io.B[M-1]),   .y(abs_b));
  div_abs #(.W(N)) u_sgn_q (.a(d_q),    .neg(sa_q ^ sb_q), .y(q_sgn));
  div_abs #(.W(M)) u_sgn_r (.a(p_q),    .neg(sa_q),        .y(r_sgn));

  // Partial remainder never exceeds |B|-1, so M stored bits suffice; the
  // shifted trial value needs one extra bit.
  assign p_sh      = {p_q, d_q[N-1]};
  assign take      = (p_sh >= {1'b0, absb_q});
  assign accept    = (state_q == IDLE) && io.start;
  assign last_step = (cnt_q == logN'(N - 1));

  assign io.DIV_aval = (state_q == IDLE);
  assign io.DIV_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.start) state_d = CALC;
      CALC:    if (last_step) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    if (!io.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      io.Q         <= '0;
      io.R         <= '0;
      io.DOUT_aval <= 1'b0;
      io.DIV_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (io.start) begin
          cnt_q        <= '0;
          io.DOUT_aval <= 1'b0;
        end
        CALC: cnt_q <= cnt_q + logN'(1);
        SIGN: begin
          io.DOUT_aval <= 1'b1;
          if (absb_q == '0) begin
            io.Q       <= '1;
            io.R       <= '0;
            io.DIV_err <= 1'b1;
          end else begin
            io.Q       <= q_sgn;
            io.R       <= r_sgn;
            io.DIV_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: load magnitudes on accept, then one shift/trial-subtract per CALC clock.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q   <= io.A[N-1];
      sb_q   <= io.B[M-1];
      absb_q <= abs_b;
      p_q    <= '0;
      d_q    <= abs_a;
    end else if (state_q == CALC) begin
      p_q <= take ? M'(p_sh - {1'b0, absb_q}) : p_sh[M-1:0];
      d_q <= {d_q[N-2:0], take};
    end
  end

endmodule

// File: tb/tb_shift_sub_div_sign.sv
// Directed and random checks of the signed sequential divider: results,
// fixed latency, handshake, divide-by-zero, wrap case and asynchronous reset.
module tb_shift_sub_div_sign;
  localparam int N    = 8;
  localparam int M    = 4;
  localparam int LOGN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_sub_div_sign_if #(.N(N), .M(M)) ifc ();

  shift_sub_div_sign #(.N(N), .M(M), .logN(LOGN)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int eerr, input bit hold, input bit scramble);
    int lat;
    lat = 0;
    for (int i = 0; i < 20 && !ifc.DIV_aval; i++) @(negedge clk);
    check("aval_ready", int'(ifc.DIV_aval), 1);
    ifc.A     = 8'(a);
    ifc.B     = 4'(b);
    ifc.start = 1'b1;
    @(negedge clk);
    check("aval_busy", int'(ifc.DIV_aval), 0);
    check("dout_cleared", int'(ifc.DOUT_aval), 0);
    if (scramble) begin
      ifc.A     = 8'($urandom);
      ifc.B     = 4'($urandom);
      ifc.start = 1'b0;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ifc.DOUT_aval) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 9);
    check("quot", int'(ifc.Q), eq);
    check("rem", int'(ifc.R), er);
    check("err", int'(ifc.DIV_err), eerr);
    check("done", int'(ifc.DIV_done), 1);
    if (hold) begin
      repeat (3) @(negedge clk);
      check("hold_done", int'(ifc.DIV_done), 1);
      check("no_retrigger", int'(ifc.DIV_aval), 0);
    end
    ifc.start = 1'b0;
    @(negedge clk);
    check("idle_aval", int'(ifc.DIV_aval), 1);
    check("idle_done", int'(ifc.DIV_done), 0);
    check("dout_held", int'(ifc.DOUT_aval), 1);
    check("quot_held", int'(ifc.Q), eq);
  endtask

  initial begin
    logic signed [7:0] ra;
    logic signed [3:0] rb;
    logic signed [7:0] t8;
    int ia, ib, eq, er, ee;

    ifc.start = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    #12;
    check("rst_q", int'(ifc.Q), 0);
    check("rst_r", int'(ifc.R), 0);
    check("rst_done", int'(ifc.DIV_done), 0);
    check("rst_dout", int'(ifc.DOUT_aval), 0);
    check("rst_err", int'(ifc.DIV_err), 0);
    check("rst_aval", int'(ifc.DIV_aval), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(  89,  7,   12,  5, 0, 1'b1, 1'b0);
    run_op( -89,  7,  -12, -5, 0, 1'b0, 1'b0);
    run_op(  89, -8,  -11,  1, 0, 1'b0, 1'b0);
    run_op( -89, -8,   11, -1, 0, 1'b0, 1'b0);
    run_op(-128, -1, -128,  0, 0, 1'b0, 1'b0);
    run_op(-128, -8,   16,  0, 0, 1'b0, 1'b0);
    run_op( 100,  0,   -1,  0, 1, 1'b1, 1'b0);

    // Abort mid-calculation with asynchronous reset.
    ifc.A     = 8'(50);
    ifc.B     = 4'(3);
    ifc.start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_q", int'(ifc.Q), 0);
    check("abort_r", int'(ifc.R), 0);
    check("abort_done", int'(ifc.DIV_done), 0);
    check("abort_dout", int'(ifc.DOUT_aval), 0);
    check("abort_err", int'(ifc.DIV_err), 0);
    check("abort_aval", int'(ifc.DIV_aval), 1);
    ifc.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(50, 3, 16, 2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 50; k++) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      ia = int'(ra);
      ib = int'(rb);
      if (ib == 0) begin
        eq = -1;
        er = 0;
        ee = 1;
      end else begin
        t8 = 8'(ia / ib);
        eq = int'(t8);
        er = ia % ib;
        ee = 0;
      end
      run_op(ia, ib, eq, er, ee, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
